// File: rtl/transpose_pingpong.sv
// transpose_pingpong: NxN matrix transpose on AXI-Stream.
// Row-major input is written into one of two banks while the other bank is
// read out column-major, so filling matrix k+1 overlaps draining matrix k.
module transpose_pingpong #(
  parameter  int VALUE_WIDTH     = 17,
  parameter  int N               = 8,
  localparam int AXIS_DATA_WIDTH = 8 * ((VALUE_WIDTH - 1) / 8 + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_aresetn,
  input  logic                       i_axis_TVALID,
  output logic                       o_axis_TREADY,
  input  logic [AXIS_DATA_WIDTH-1:0] i_axis_TDATA,
  input  logic                       i_axis_TLAST,
  output logic                       o_axis_TVALID,
  input  logic                       i_axis_TREADY,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_TDATA,
  output logic                       o_axis_TLAST,
  output logic                       o_tlast_err
);

  localparam int DEPTH = N * N;
  localparam int CW    = $clog2(N);
  localparam int AW    = $clog2(DEPTH);

  logic signed [VALUE_WIDTH-1:0] bank [2][DEPTH];

  logic [1:0]    full;
  logic          wr_sel;
  logic          rd_sel;
  logic [CW-1:0] wr_r;
  logic [CW-1:0] wr_c;
  logic [CW-1:0] rd_r;
  logic [CW-1:0] rd_c;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          accept;
  logic          wr_last;
  logic          load;
  logic          rd_last;
  logic          pad_unused;

  logic signed [VALUE_WIDTH-1:0] in_value;
  logic signed [VALUE_WIDTH-1:0] rd_value_p0;

  // Widen a stored element to the bus width, replicating its sign bit.
  function automatic logic signed [AXIS_DATA_WIDTH-1:0] sign_extend(
    input logic signed [VALUE_WIDTH-1:0] v
  );
    logic signed [AXIS_DATA_WIDTH-1:0] r;
    r = v;
    return r;
  endfunction

  // Pad bits above VALUE_WIDTH carry no information.
  assign pad_unused = ^i_axis_TDATA;
  assign in_value   = signed'(i_axis_TDATA[VALUE_WIDTH-1:0]);

  // Write side: ready depends only on the fill state of the bank being written.
  assign o_axis_TREADY = !full[wr_sel];
  assign accept        = i_axis_TVALID && o_axis_TREADY;
  assign wr_last       = (wr_r == CW'(N - 1)) && (wr_c == CW'(N - 1));
  assign wr_addr       = AW'(wr_r) * AW'(N) + AW'(wr_c);

  // Read side: element (r, c) of the stored row-major matrix, r running fastest.
  assign load        = full[rd_sel] && (!o_axis_TVALID || i_axis_TREADY);
  assign rd_last     = (rd_r == CW'(N - 1)) && (rd_c == CW'(N - 1));
  assign rd_addr     = AW'(rd_r) * AW'(N) + AW'(rd_c);
  assign rd_value_p0 = bank[rd_sel][rd_addr];

  // Element storage; no reset since contents are only read after being written.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      bank[wr_sel][wr_addr] <= in_value;
    end
  end

  // Write counters, bank select and the TLAST framing check.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      wr_r        <= '0;
      wr_c        <= '0;
      wr_sel      <= 1'b0;
      o_tlast_err <= 1'b0;
    end else begin
      o_tlast_err <= accept && (i_axis_TLAST != wr_last);
      if (accept) begin
        if (wr_last) begin
          wr_r   <= '0;
          wr_c   <= '0;
          wr_sel <= ~wr_sel;
        end else if (wr_c == CW'(N - 1)) begin
          wr_c <= '0;
          wr_r <= wr_r + 1'b1;
        end else begin
          wr_c <= wr_c + 1'b1;
        end
      end
    end
  end

  // Bank fill flags: fill-complete and drain-complete always hit different banks.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      full <= '0;
    end else begin
      if (load && rd_last) begin
        full[rd_sel] <= 1'b0;
      end
      if (accept && wr_last) begin
        full[wr_sel] <= 1'b1;
      end
    end
  end

  // Output register stage: loads the next column-major element when free or consumed.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      rd_r          <= '0;
      rd_c          <= '0;
      rd_sel        <= 1'b0;
      o_axis_TVALID <= 1'b0;
      o_axis_TDATA  <= '0;
      o_axis_TLAST  <= 1'b0;
    end else if (load) begin
      o_axis_TVALID <= 1'b1;
      o_axis_TDATA  <= sign_extend(rd_value_p0);
      o_axis_TLAST  <= rd_last;
      if (rd_last) begin
        rd_r   <= '0;
        rd_c   <= '0;
        rd_sel <= ~rd_sel;
      end else if (rd_r == CW'(N - 1)) begin
        rd_r <= '0;
        rd_c <= rd_c + 1'b1;
      end else begin
        rd_r <= rd_r + 1'b1;
      end
    end else if (i_axis_TREADY) begin
      o_axis_TVALID <= 1'b0;
      o_axis_TLAST  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_transpose_pingpong.sv
// Directed bench for transpose_pingpong: an N=8 instance for most scenarios
// and an N=4 instance for the small-matrix case.
module tb_transpose_pingpong;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid8 = 0, in_last8 = 0, out_ready8 = 1;
  logic [23:0] in_data8 = '0;
  logic        in_ready8, out_valid8, out_last8, terr8_o;
  logic [23:0] out_data8;

  logic        in_valid4 = 0, in_last4 = 0, out_ready4 = 1;
  logic [23:0] in_data4 = '0;
  logic        in_ready4, out_valid4, out_last4, terr4_o;
  logic [23:0] out_data4;

  transpose_pingpong #(.VALUE_WIDTH(17), .N(8)) dut8 (
    .i_clk(clk), .i_aresetn(rst_n),
    .i_axis_TVALID(in_valid8), .o_axis_TREADY(in_ready8),
    .i_axis_TDATA(in_data8), .i_axis_TLAST(in_last8),
    .o_axis_TVALID(out_valid8), .i_axis_TREADY(out_ready8),
    .o_axis_TDATA(out_data8), .o_axis_TLAST(out_last8),
    .o_tlast_err(terr8_o)
  );

  transpose_pingpong #(.VALUE_WIDTH(17), .N(4)) dut4 (
    .i_clk(clk), .i_aresetn(rst_n),
    .i_axis_TVALID(in_valid4), .o_axis_TREADY(in_ready4),
    .i_axis_TDATA(in_data4), .i_axis_TLAST(in_last4),
    .o_axis_TVALID(out_valid4), .i_axis_TREADY(out_ready4),
    .o_axis_TDATA(out_data4), .o_axis_TLAST(out_last4),
    .o_tlast_err(terr4_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  int          cyc = 0;
  logic [23:0] q8d[$], q4d[$];
  logic        q8l[$], q4l[$];
  int          q8c[$];
  int          acc_cyc[$];
  int          terr8 = 0, terr4 = 0, unstable8 = 0, stalls = 0;
  logic        prev_stall8 = 0, prev_l8 = 0;
  logic [23:0] prev_d8 = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected transposed value at output position k for an n x n matrix of 1..n*n.
  function automatic int tval(input int k, input int n);
    return (k % n) * n + k / n + 1;
  endfunction

  // Output collection, stall-stability and error-pulse counting.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (out_valid8 && out_ready8) begin
      q8d.push_back(out_data8);
      q8l.push_back(out_last8);
      q8c.push_back(cyc);
    end
    if (prev_stall8 && (out_data8 !== prev_d8 || out_last8 !== prev_l8 || !out_valid8))
      unstable8++;
    prev_stall8 <= out_valid8 && !out_ready8;
    prev_d8     <= out_data8;
    prev_l8     <= out_last8;
    if (terr8_o) terr8++;
    if (out_valid4 && out_ready4) begin
      q4d.push_back(out_data4);
      q4l.push_back(out_last4);
    end
    if (terr4_o) terr4++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    in_valid8 = 0; in_last8 = 0; out_ready8 = 1;
    in_valid4 = 0; in_last4 = 0; out_ready4 = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    q8d.delete(); q8l.delete(); q8c.delete(); q4d.delete(); q4l.delete();
    acc_cyc.delete();
    terr8 = 0; terr4 = 0; unstable8 = 0; stalls = 0;
  endtask

  // Offer values sgn*(first..first+count-1); TLAST where (i % n2) == last_pos.
  task automatic feed(input bit sel, input int first, input int count, input int sgn,
                      input int last_pos, input int n2);
    int  v;
    int  t;
    bit  rdy;
    for (int i = 0; i < count; i++) begin
      @(negedge clk);
      v = sgn * (first + i);
      if (sel) begin
        in_valid4 = 1; in_data4 = {7'h2a, 17'(v)}; in_last4 = ((i % n2) == last_pos);
      end else begin
        in_valid8 = 1; in_data8 = {7'h2a, 17'(v)}; in_last8 = ((i % n2) == last_pos);
      end
      t = 0;
      forever begin
        rdy = sel ? in_ready4 : in_ready8;
        @(posedge clk);
        if (rdy) break;
        stalls++;
        t++;
        if (t > 3000) begin
          check("feed_timeout", 0, 1);
          #1;
          in_valid8 = 0; in_valid4 = 0;
          return;
        end
        @(negedge clk);
      end
      if (!sel) acc_cyc.push_back(cyc);
    end
    #1;
    in_valid8 = 0; in_last8 = 0; in_valid4 = 0; in_last4 = 0;
  endtask

  task automatic wait_out(input bit sel, input int n);
    for (int t = 0; t < 2000 && (sel ? q4d.size() : q8d.size()) < n; t++) @(negedge clk);
    check("beat_count", sel ? q4d.size() : q8d.size(), n);
  endtask

  task automatic compare(input bit sel, input string pfx, input int mats, input int n,
                         input int sgn);
    int          nn;
    logic [23:0] e;
    logic [23:0] got;
    logic        gl;
    nn = n * n;
    for (int m = 0; m < mats; m++) begin
      for (int k = 0; k < nn; k++) begin
        e   = 24'(sgn * (m * nn + tval(k, n)));
        got = sel ? q4d[m * nn + k] : q8d[m * nn + k];
        gl  = sel ? q4l[m * nn + k] : q8l[m * nn + k];
        check($sformatf("%s_data%0d", pfx, m * nn + k), got, e);
        check($sformatf("%s_last%0d", pfx, m * nn + k), gl, (k == nn - 1));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          gaps;
    logic [6:0]  pad;

    // Reset state
    #2 rst_n = 0;
    #5;
    check("rst_tvalid", out_valid8, 0);
    check("rst_tdata", out_data8, 0);
    check("rst_tlast", out_last8, 0);
    check("rst_terr", terr8_o, 0);
    check("rst_tready", in_ready8, 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    do_reset();

    // 1: single matrix, latency, transpose order
    feed(0, 1, 64, 1, 63, 64);
    check("s1_lat_edge0", out_valid8, 0);
    @(posedge clk); #1;
    check("s1_lat_edge1", out_valid8, 1);
    check("s1_first_data", out_data8, 1);
    wait_out(0, 64);
    compare(0, "s1", 1, 8, 1);
    check("s1_terr", terr8, 0);

    // 2: two matrices back-to-back, no stall, no output gap
    do_reset();
    feed(0, 1, 128, 1, 63, 64);
    wait_out(0, 128);
    compare(0, "s2", 2, 8, 1);
    check("s2_stalls", stalls, 0);
    gaps = 0;
    for (int k = 1; k < q8c.size(); k++) if (q8c[k] - q8c[k-1] != 1) gaps++;
    check("s2_gaps", gaps, 0);

    // 3: downstream blocked while three matrices are offered
    do_reset();
    out_ready8 = 0;
    fork
      feed(0, 1, 192, 1, 63, 64);
      begin
        for (int t = 0; t < 1000 && acc_cyc.size() < 128; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("s3_accepted", acc_cyc.size(), 128);
        check("s3_tready_low", in_ready8, 0);
        check("s3_hold_valid", out_valid8, 1);
        check("s3_hold_data", out_data8, 1);
        out_ready8 = 1;
      end
    join
    wait_out(0, 192);
    compare(0, "s3", 3, 8, 1);
    check("s3_stable", unstable8, 0);
    check("s3_resume_cycle", acc_cyc[128], q8c[63]);

    // 4: downstream ready toggling every cycle
    do_reset();
    fork
      feed(0, 1, 64, 1, 63, 64);
      begin
        for (int t = 0; t < 600 && q8d.size() < 64; t++) begin
          @(negedge clk);
          out_ready8 = ~out_ready8;
        end
        out_ready8 = 1;
      end
    join
    wait_out(0, 64);
    compare(0, "s4", 1, 8, 1);
    check("s4_stable", unstable8, 0);

    // 5: negative values, sign extension into pad bits
    do_reset();
    feed(0, 1, 64, -1, 63, 64);
    wait_out(0, 64);
    compare(0, "s5", 1, 8, -1);
    pad = q8d[0][23:17];
    check("s5_pad_ones", pad, 7'h7f);

    // 6: misplaced TLAST, then reset mid-matrix and a clean matrix
    do_reset();
    feed(0, 1, 64, 1, 31, 64);
    wait_out(0, 64);
    compare(0, "s6a", 1, 8, 1);
    check("s6_terr_pulses", terr8, 2);
    feed(0, 100, 20, 1, 63, 64);
    do_reset();
    check("s6_rst_tready", in_ready8, 1);
    check("s6_rst_tvalid", out_valid8, 0);
    feed(0, 1, 64, 1, 63, 64);
    wait_out(0, 64);
    compare(0, "s6b", 1, 8, 1);
    check("s6_terr_clean", terr8, 0);

    // 7: N=4 instance
    do_reset();
    feed(1, 1, 16, 1, 15, 16);
    check("s7_lat_edge0", out_valid4, 0);
    @(posedge clk); #1;
    check("s7_lat_edge1", out_valid4, 1);
    wait_out(1, 16);
    compare(1, "s7", 1, 4, 1);
    check("s7_terr", terr4, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
